// File: rtl/coeff_reorder.sv
// Collects run-length coded levels of one 4x4 block into a raster-ordered buffer
// and streams the 16 coefficients out in raster order.
module coeff_reorder #(
   parameter int LEVEL_W = 13
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic               Start,
   input  logic [4:0]         TotalCoeff,
   input  logic [3:0]         TotalZeros,
   output logic               StartReady,
   input  logic [LEVEL_W-1:0] LevelIn,
   input  logic [3:0]         RunBefore,
   input  logic               WrReq,
   output logic               InReady,
   input  logic               BlockDone,
   output logic [LEVEL_W-1:0] CoeffOut,
   output logic [3:0]         CoeffIdx,
   output logic               OutValid,
   input  logic               OutReady,
   output logic               OutLast,
   output logic               Error
);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t             state, stateNext;
   logic [LEVEL_W-1:0] coeffBuf [16];
   logic signed [5:0]  pos;
   logic [4:0]         cnt, tc;
   logic [3:0]         idx;
   logic               errReg;

   logic              startAcc, wrAcc, wrOk, beatAcc, badStart;
   logic [5:0]        posInit, coeffSum;
   logic [4:0]        cntAfter;

   function automatic logic [3:0] zigzag(input logic [3:0] s);
      case (s)
         4'd0:  zigzag = 4'd0;
         4'd1:  zigzag = 4'd1;
         4'd2:  zigzag = 4'd4;
         4'd3:  zigzag = 4'd8;
         4'd4:  zigzag = 4'd5;
         4'd5:  zigzag = 4'd2;
         4'd6:  zigzag = 4'd3;
         4'd7:  zigzag = 4'd6;
         4'd8:  zigzag = 4'd9;
         4'd9:  zigzag = 4'd12;
         4'd10: zigzag = 4'd13;
         4'd11: zigzag = 4'd10;
         4'd12: zigzag = 4'd7;
         4'd13: zigzag = 4'd11;
         4'd14: zigzag = 4'd14;
         default: zigzag = 4'd15;
      endcase
   endfunction

   always_comb begin
      stateNext  = state;
      StartReady = nReset && (state == IDLE);
      InReady    = nReset && (state == FILL);
      OutValid   = nReset && (state == DRAIN);
      case (state)
         IDLE:    if (Start) stateNext = FILL;
         FILL:    if (BlockDone) stateNext = DRAIN;
         DRAIN:   if (OutReady && idx == 4'd15) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign startAcc = StartReady && Start;
   assign wrAcc    = InReady && WrReq;
   // Positions above 15 only arise from an already-flagged bad header; treat as discard.
   assign wrOk     = wrAcc && (cnt < tc) && !pos[5] && !pos[4];
   assign beatAcc  = OutValid && OutReady;
   assign coeffSum = {1'b0, TotalCoeff} + {2'b00, TotalZeros};
   assign posInit  = coeffSum - 6'd1;
   assign badStart = (TotalCoeff > 5'd16) || (coeffSum > 6'd16);
   assign cntAfter = cnt + {4'd0, wrOk};

   always_ff @(posedge Clk) begin
      if (!nReset) begin
         state  <= IDLE;
         pos    <= '0;
         cnt    <= '0;
         tc     <= '0;
         idx    <= '0;
         errReg <= 1'b0;
         for (int i = 0; i < 16; i++) coeffBuf[i] <= '0;
      end else begin
         state <= stateNext;
         if (startAcc) begin
            pos    <= posInit;
            cnt    <= '0;
            tc     <= TotalCoeff;
            errReg <= badStart;
            for (int i = 0; i < 16; i++) coeffBuf[i] <= '0;
         end
         if (wrAcc) begin
            if (wrOk) begin
               coeffBuf[zigzag(pos[3:0])] <= LevelIn;
               pos <= pos - 6'sd1 - $signed({2'b00, RunBefore});
               cnt <= cntAfter;
            end else begin
               errReg <= 1'b1;
            end
         end
         // The level written alongside BlockDone still counts toward the total.
         if (InReady && BlockDone && (cntAfter < tc)) errReg <= 1'b1;
         if (beatAcc) idx <= idx + 4'd1;
      end
   end

   assign CoeffOut = coeffBuf[idx];
   assign CoeffIdx = idx;
   assign OutLast  = OutValid && (idx == 4'd15);
   assign Error    = errReg;

endmodule

// File: doc/coeff_reorder.md
COEFF_REORDER -- requirements
Module: coeff_reorder

Interface
REQ-001 SHALL have parameter LEVEL_W, default 13, meaning signed coefficient width, matching the level decoder output.
REQ-002 SHALL have port Clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port nReset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port Start  input  1  block-start strobe; qualifies TotalCoeff/TotalZeros.
REQ-005 SHALL have port TotalCoeff  input  5  non-zero coefficient count of the block, 0..16.
REQ-006 SHALL have port TotalZeros  input  4  zeros before the last non-zero coefficient, 0..15.
REQ-007 SHALL have port StartReady  output  1  high when Start is accepted.
REQ-008 SHALL have port LevelIn  input  LEVEL_W  signed level, highest-frequency first.
REQ-009 SHALL have port RunBefore  input  4  zeros preceding this level in scan order.
REQ-010 SHALL have port WrReq  input  1  LevelIn/RunBefore valid.
REQ-011 SHALL have port InReady  output  1  high when WrReq is accepted.
REQ-012 SHALL have port BlockDone  input  1  end of the current 4x4 block's level/run data.
REQ-013 SHALL have port CoeffOut  output  LEVEL_W  coefficient in raster order.
REQ-014 SHALL have port CoeffIdx  output  4  raster index of CoeffOut.
REQ-015 SHALL have port OutValid  output  1  CoeffOut valid.
REQ-016 SHALL have port OutReady  input  1  downstream accepts the beat.
REQ-017 SHALL have port OutLast  output  1  high with beat CoeffIdx=15.
REQ-018 SHALL have port Error  output  1  sticky block error; cleared on accepted Start.

Function
REQ-019 SHALL implement states IDLE, FILL, DRAIN; StartReady=(IDLE), InReady=(FILL), OutValid=(DRAIN).
REQ-020 IDLE: on Start SHALL clear all 16 buffer entries to 0, set Pos=TotalCoeff+TotalZeros-1 (6-bit signed), Cnt=0, Error=0, and go to FILL next cycle.
REQ-021 On Start, TotalCoeff>16 or TotalCoeff+TotalZeros>16 SHALL set Error; the block still proceeds to FILL.
REQ-022 FILL: on WrReq with Cnt<TotalCoeff and Pos>=0, SHALL write LevelIn to raster address Zigzag[Pos], then Pos<=Pos-1-RunBefore and Cnt<=Cnt+1.
REQ-023 Zigzag[0..15] SHALL be 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15 (scan index to raster index).
REQ-024 On WrReq with Cnt>=TotalCoeff or Pos<0, SHALL discard the level and set Error.
REQ-025 FILL: BlockDone SHALL move to DRAIN next cycle; a WrReq in the same cycle SHALL be written first.
REQ-026 BlockDone with Cnt<TotalCoeff SHALL set Error and still drain.
REQ-027 DRAIN: CoeffIdx SHALL start at 0 and CoeffOut=buffer[CoeffIdx]; the beat completes when OutValid&&OutReady, then CoeffIdx increments.
REQ-028 CoeffOut/CoeffIdx SHALL be held stable while OutValid&&!OutReady.
REQ-029 The beat with CoeffIdx=15 SHALL assert OutLast; on its acceptance the state SHALL return to IDLE, and StartReady SHALL be high the following cycle.
REQ-030 Start outside IDLE, WrReq outside FILL, and BlockDone outside FILL SHALL be ignored with no state change.
REQ-031 TotalCoeff=0 SHALL be legal: Start then BlockDone drains 16 zero beats, Error=0.
REQ-032 Latency SHALL be 1 cycle from the BlockDone cycle to the first OutValid; throughput 1 coefficient/cycle in both FILL and DRAIN.

Reset
REQ-033 nReset low at a rising edge SHALL force IDLE, buffer=0, Pos=0, Cnt=0, CoeffIdx=0, Error=0, OutValid=0, OutLast=0, InReady=0, StartReady=0 during reset; StartReady=1 the first cycle after release.
REQ-034 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the block with no further output beats.

Verification
REQ-035 Start TC=3,TZ=2; levels (5,run1),(-2,run0),(1,run0); BlockDone; OutReady=1 -> 16 beats with raster[1]=1, raster[4]=-2, raster[5]=5, all others 0; OutLast on idx 15; Error=0.
REQ-036 Start TC=16,TZ=0; levels 16..1 with run0 -> raster[Zigzag[k]]=k+1 for k=0..15; Error=0.
REQ-037 Drain with OutReady toggling 1,0,0,1,... -> CoeffOut/CoeffIdx held during stalls; exactly 16 accepted beats, in order 0..15.
REQ-038 Start TC=2,TZ=0; 3 WrReq -> third level discarded, Error=1; TC=16,TZ=1 -> Error=1 at Start.
REQ-039 WrReq coincident with BlockDone -> level written; first OutValid on the next cycle. nReset pulsed mid-DRAIN at idx 7 -> OutValid=0 next cycle; a new block then decodes correctly.
REQ-040 Start TC=0,TZ=0 immediately followed by BlockDone -> 16 zero beats, Error=0.
